// File: rtl/dmux_route_ctrl.sv
// dmux_route_ctrl: valid/ready sequencer steering one source byte to destination A or B
// Optional broadcast (IN_BCAST loads both sides) is compiled in when DMUX_BCAST_EN is defined.
module dmux_route_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_SEL,
    input  logic             IN_BCAST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] A_DATA,
    output logic             A_VALID,
    input  logic             A_READY,
    output logic [WIDTH-1:0] B_DATA,
    output logic             B_VALID,
    input  logic             B_READY,
    output logic             BUSY,
    output logic [7:0]       CNT_A,
    output logic [7:0]       CNT_B
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_A    = 2'd1;
    localparam logic [1:0] SEND_B    = 2'd2;
    localparam logic [1:0] SEND_BOTH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [7:0]       cnt_a_q, cnt_a_d;
    logic [7:0]       cnt_b_q, cnt_b_d;

`ifndef DMUX_BCAST_EN
    logic unused_bcast;
    assign unused_bcast = IN_BCAST;
`endif

    // Next-state, data-load and delivery-count logic; unselected side always holds
    always_comb begin
        state_d   = state_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
`ifdef DMUX_BCAST_EN
                    if (IN_BCAST) begin
                        a_data_d  = IN_DATA;
                        b_data_d  = IN_DATA;
                        a_valid_d = 1'b1;
                        b_valid_d = 1'b1;
                        state_d   = SEND_BOTH;
                    end else
`endif
                    if (IN_SEL) begin
                        b_data_d  = IN_DATA;
                        b_valid_d = 1'b1;
                        state_d   = SEND_B;
                    end else begin
                        a_data_d  = IN_DATA;
                        a_valid_d = 1'b1;
                        state_d   = SEND_A;
                    end
                end
            end
            SEND_A: begin
                if (A_READY) begin
                    a_valid_d = 1'b0;
                    cnt_a_d   = cnt_a_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            SEND_B: begin
                if (B_READY) begin
                    b_valid_d = 1'b0;
                    cnt_b_d   = cnt_b_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            default: begin
`ifdef DMUX_BCAST_EN
                // Each side retires on its own ready; leave once neither is outstanding
                if (a_valid_q && A_READY) begin
                    a_valid_d = 1'b0;
                    cnt_a_d   = cnt_a_q + 8'd1;
                end
                if (b_valid_q && B_READY) begin
                    b_valid_d = 1'b0;
                    cnt_b_d   = cnt_b_q + 8'd1;
                end
                if (!a_valid_d && !b_valid_d)
                    state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
        endcase
    end

    // State and output registers; async reset drops any pending byte uncounted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            cnt_a_q   <= 8'd0;
            cnt_b_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    assign IN_READY = (state_q == IDLE);
    assign BUSY     = (state_q != IDLE);
    assign A_DATA   = a_data_q;
    assign B_DATA   = b_data_q;
    assign A_VALID  = a_valid_q;
    assign B_VALID  = b_valid_q;
    assign CNT_A    = cnt_a_q;
    assign CNT_B    = cnt_b_q;

endmodule

// File: tb/tb_dmux_route_ctrl.sv
// tb_dmux_route_ctrl: randomized bench against a transaction-level model of the demux controller
module tb_dmux_route_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_sel, in_bcast, in_valid, in_ready;
    logic [7:0] a_data, b_data, cnt_a, cnt_b;
    logic       a_valid, a_ready, b_valid, b_ready, busy;

    int vectors = 0;
    int errors = 0;

    // Reference model: pending bytes per destination and delivery totals
    logic [7:0] m_a_data, m_b_data, m_cnt_a, m_cnt_b;
    logic       m_a_pend, m_b_pend, m_accepted;

    dmux_route_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .IN_DATA(in_data), .IN_SEL(in_sel), .IN_BCAST(in_bcast),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .A_DATA(a_data), .A_VALID(a_valid), .A_READY(a_ready),
        .B_DATA(b_data), .B_VALID(b_valid), .B_READY(b_ready),
        .BUSY(busy), .CNT_A(cnt_a), .CNT_B(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a_data = 8'h00; m_b_data = 8'h00;
        m_cnt_a = 8'h00; m_cnt_b = 8'h00;
        m_a_pend = 1'b0; m_b_pend = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic check_all();
        logic idle;
        idle = !m_a_pend && !m_b_pend;
        check("in_ready", in_ready, idle);
        check("busy", busy, !idle);
        check("a_data", a_data, m_a_data);
        check("a_valid", a_valid, m_a_pend);
        check("b_data", b_data, m_b_data);
        check("b_valid", b_valid, m_b_pend);
        check("cnt_a", cnt_a, m_cnt_a);
        check("cnt_b", cnt_b, m_cnt_b);
    endtask

    // One rising edge: update the model from the inputs it saw, then compare
    task automatic tick();
        @(posedge clk);
        m_accepted = 1'b0;
        if (!m_a_pend && !m_b_pend) begin
            if (in_valid) begin
                m_accepted = 1'b1;
`ifdef DMUX_BCAST_EN
                if (in_bcast) begin
                    m_a_data = in_data; m_b_data = in_data;
                    m_a_pend = 1'b1; m_b_pend = 1'b1;
                end else
`endif
                if (in_sel) begin
                    m_b_data = in_data; m_b_pend = 1'b1;
                end else begin
                    m_a_data = in_data; m_a_pend = 1'b1;
                end
            end
        end else begin
            if (m_a_pend && a_ready) begin m_a_pend = 1'b0; m_cnt_a++; end
            if (m_b_pend && b_ready) begin m_b_pend = 1'b0; m_cnt_b++; end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic s, input logic bc, input logic [7:0] d,
                         input logic ar, input logic br);
        in_valid = v; in_sel = s; in_bcast = bc; in_data = d;
        a_ready = ar; b_ready = br;
    endtask

    initial begin
        // Reset with a byte offered: nothing may be captured
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1);
        model_reset();
        #2;
        check_all();
        #6 reset = 1'b0;
        #1;
        check_all();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // 0x5A to A with ready held low three cycles
        drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        a_ready = 1'b1;
        tick();
        check("a_done_cnt", cnt_a, 8'd1);
        check("b_untouched", b_data, 8'h00);

        // 0x11 to B then 0x22 to A with both readies high
        drive(1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("b_hold", b_data, 8'h11);

        // 256 deliveries to A wrap its counter back to the starting value
        drive(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
        repeat (512) tick();
        check("cnt_a_wrap", cnt_a, 8'd2);
        check("cnt_b_wrap", cnt_b, 8'd1);

        // Async reset while a byte waits for B: dropped immediately, not counted
        reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("b_pending", b_valid, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b0;

`ifdef DMUX_BCAST_EN
        // Broadcast retiring A then B on separate edges
        drive(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        tick();
        b_ready = 1'b1;
        tick();
        check("bcast_cnt_a", cnt_a, 8'd1);
        check("bcast_cnt_b", cnt_b, 8'd1);
        check("bcast_busy", busy, 1'b0);
`endif

        // Random traffic; an offered byte stays stable until taken
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || m_accepted) begin
                in_valid = ($urandom_range(0, 9) < 6);
                in_sel = 1'($urandom);
                in_bcast = ($urandom_range(0, 3) == 0);
                in_data = 8'($urandom);
            end
            a_ready = 1'($urandom);
            b_ready = 1'($urandom);
            if (i == 1500) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_all();
                #1 reset = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
